// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALUctr encodings, register constants
// and the ID/EX control bundle.
package cpu_pkg;

  localparam logic [2:0] ALU_ADDU = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_SUBU = 3'b100;
  localparam logic [2:0] ALU_SUB  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic valid;
    logic reg_wr;
    logic mem_wr;
    logic mem_to_reg;
  } ex_ctrl_t;

endpackage

// File: rtl/forward_unit.sv
// Per-operand bypass select: EX/MEM over MEM/WB over register file.
// Register zero is never bypassed.
module forward_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RA_W  = 5
) (
  input  logic [RA_W-1:0]  reg_addr,
  input  logic [WIDTH-1:0] reg_data,
  input  logic             em_reg_wr,
  input  logic [RA_W-1:0]  em_rw,
  input  logic [WIDTH-1:0] em_result,
  input  logic             mw_reg_wr,
  input  logic [RA_W-1:0]  mw_rw,
  input  logic [WIDTH-1:0] mw_data,
  output logic [WIDTH-1:0] fwd_data
);

  logic nz;
  logic em_hit;
  logic mw_hit;

  assign nz = (reg_addr != RA_W'(REG_ZERO));
  assign em_hit = em_reg_wr & nz & (em_rw == reg_addr);
  assign mw_hit = mw_reg_wr & nz & (mw_rw == reg_addr);

  always_comb begin
    fwd_data = reg_data;
    if (em_hit) begin
      fwd_data = em_result;
    end else if (mw_hit) begin
      fwd_data = mw_data;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX register with operand bypass and load-use stall.
// A stall or flush turns the captured instruction into a bubble.
module ex_operand_stage
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RA_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic [RA_W-1:0]  id_rw,
  input  logic [WIDTH-1:0] id_busA,
  input  logic [WIDTH-1:0] id_busB,
  input  logic [WIDTH-1:0] id_imm,
  input  logic [2:0]       id_alu_ctr,
  input  logic             id_alu_src,
  input  logic             id_reg_wr,
  input  logic             id_mem_wr,
  input  logic             id_mem_to_reg,
  input  logic             flush,
  input  logic             em_reg_wr,
  input  logic [RA_W-1:0]  em_rw,
  input  logic [WIDTH-1:0] em_result,
  input  logic             mw_reg_wr,
  input  logic [RA_W-1:0]  mw_rw,
  input  logic [WIDTH-1:0] mw_data,
  output logic             stall,
  output logic             ex_valid,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctr,
  output logic [RA_W-1:0]  ex_rw,
  output logic [WIDTH-1:0] ex_store_data,
  output logic             ex_reg_wr,
  output logic             ex_mem_wr,
  output logic             ex_mem_to_reg
);

  ex_ctrl_t         ctrl_q, ctrl_d;
  logic [RA_W-1:0]  rs_q, rt_q, rw_q;
  logic [WIDTH-1:0] bus_a_q, bus_b_q, imm_q;
  logic [2:0]       alu_ctr_q;
  logic             alu_src_q;

  logic             bubble;
  logic             uses_rt;
  logic             hazard;
  logic [WIDTH-1:0] fwd_a, fwd_b;

  assign uses_rt = ~id_alu_src | id_mem_wr;

  assign hazard = ctrl_q.valid & ctrl_q.mem_to_reg & ctrl_q.reg_wr
                & (rw_q != RA_W'(REG_ZERO)) & id_valid
                & ((rw_q == id_rs) | (uses_rt & (rw_q == id_rt)));

  assign stall  = hazard & ~flush;
  assign bubble = flush | stall;

  always_comb begin
    ctrl_d = '0;
    if (!bubble) begin
      ctrl_d.valid      = id_valid;
      ctrl_d.reg_wr     = id_reg_wr & id_valid;
      ctrl_d.mem_wr     = id_mem_wr & id_valid;
      ctrl_d.mem_to_reg = id_mem_to_reg & id_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  // Data fields of a bubble are never observed, so they just hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_q      <= '0;
      rt_q      <= '0;
      rw_q      <= '0;
      bus_a_q   <= '0;
      bus_b_q   <= '0;
      imm_q     <= '0;
      alu_ctr_q <= '0;
      alu_src_q <= 1'b0;
    end else if (!bubble) begin
      rs_q      <= id_rs;
      rt_q      <= id_rt;
      rw_q      <= id_rw;
      bus_a_q   <= id_busA;
      bus_b_q   <= id_busB;
      imm_q     <= id_imm;
      alu_ctr_q <= id_alu_ctr;
      alu_src_q <= id_alu_src;
    end
  end

  forward_unit #(.WIDTH(WIDTH), .RA_W(RA_W)) u_fwd_a (
    .reg_addr  (rs_q),
    .reg_data  (bus_a_q),
    .em_reg_wr (em_reg_wr),
    .em_rw     (em_rw),
    .em_result (em_result),
    .mw_reg_wr (mw_reg_wr),
    .mw_rw     (mw_rw),
    .mw_data   (mw_data),
    .fwd_data  (fwd_a)
  );

  forward_unit #(.WIDTH(WIDTH), .RA_W(RA_W)) u_fwd_b (
    .reg_addr  (rt_q),
    .reg_data  (bus_b_q),
    .em_reg_wr (em_reg_wr),
    .em_rw     (em_rw),
    .em_result (em_result),
    .mw_reg_wr (mw_reg_wr),
    .mw_rw     (mw_rw),
    .mw_data   (mw_data),
    .fwd_data  (fwd_b)
  );

  assign alu_a         = fwd_a;
  assign alu_b         = alu_src_q ? imm_q : fwd_b;
  assign ex_store_data = fwd_b;
  assign alu_ctr       = alu_ctr_q;
  assign ex_rw         = rw_q;
  assign ex_valid      = ctrl_q.valid;
  assign ex_reg_wr     = ctrl_q.reg_wr;
  assign ex_mem_wr     = ctrl_q.mem_wr;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed pins plus random traffic
// against a behavioural ID/EX model.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 0;
  logic [4:0]  id_rs = 0, id_rt = 0, id_rw = 0;
  logic [31:0] id_busA = 0, id_busB = 0, id_imm = 0;
  logic [2:0]  id_alu_ctr = 0;
  logic        id_alu_src = 0, id_reg_wr = 0, id_mem_wr = 0;
  logic        id_mem_to_reg = 0, flush = 0;
  logic        em_reg_wr = 0, mw_reg_wr = 0;
  logic [4:0]  em_rw = 0, mw_rw = 0;
  logic [31:0] em_result = 0, mw_data = 0;

  logic        stall, ex_valid;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [2:0]  alu_ctr;
  logic [4:0]  ex_rw;
  logic        ex_reg_wr, ex_mem_wr, ex_mem_to_reg;

  int checks = 0;
  int errors = 0;

  ex_operand_stage #(.WIDTH(32), .RA_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rw(id_rw), .id_busA(id_busA), .id_busB(id_busB),
    .id_imm(id_imm), .id_alu_ctr(id_alu_ctr),
    .id_alu_src(id_alu_src), .id_reg_wr(id_reg_wr),
    .id_mem_wr(id_mem_wr), .id_mem_to_reg(id_mem_to_reg),
    .flush(flush),
    .em_reg_wr(em_reg_wr), .em_rw(em_rw), .em_result(em_result),
    .mw_reg_wr(mw_reg_wr), .mw_rw(mw_rw), .mw_data(mw_data),
    .stall(stall), .ex_valid(ex_valid),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr),
    .ex_rw(ex_rw), .ex_store_data(ex_store_data),
    .ex_reg_wr(ex_reg_wr), .ex_mem_wr(ex_mem_wr),
    .ex_mem_to_reg(ex_mem_to_reg)
  );

  always #5 clk = ~clk;

  // Instruction currently sitting in EX, as the model sees it.
  typedef struct {
    bit        v, rwe, mwe, ld, src;
    bit [2:0]  ctr;
    bit [4:0]  rs, rt, rw;
    bit [31:0] a, b, imm;
  } ex_t;

  ex_t m;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit [31:0] fwd(bit [4:0] r, bit [31:0] d);
    if (r == 0) return d;
    if (em_reg_wr && em_rw == r) return em_result;
    if (mw_reg_wr && mw_rw == r) return mw_data;
    return d;
  endfunction

  function automatic bit exp_stall();
    bit reads_rt, dep;
    if (flush || !id_valid) return 0;
    if (!(m.v && m.ld && m.rwe) || m.rw == 0) return 0;
    reads_rt = !id_alu_src || id_mem_wr;
    dep = (m.rw == id_rs) || (reads_rt && m.rw == id_rt);
    return dep;
  endfunction

  task automatic compare_all();
    bit [31:0] fb;
    fb = fwd(m.rt, m.b);
    chk("stall", stall, exp_stall());
    chk("ex_valid", ex_valid, m.v);
    chk("alu_a", alu_a, fwd(m.rs, m.a));
    chk("alu_b", alu_b, m.src ? m.imm : fb);
    chk("store_data", ex_store_data, fb);
    chk("alu_ctr", alu_ctr, m.ctr);
    chk("ex_rw", ex_rw, m.rw);
    chk("ex_reg_wr", ex_reg_wr, m.rwe);
    chk("ex_mem_wr", ex_mem_wr, m.mwe);
    chk("ex_mem_to_reg", ex_mem_to_reg, m.ld);
  endtask

  // One cycle: check at negedge, advance model across posedge.
  task automatic step();
    ex_t n;
    @(negedge clk);
    compare_all();
    n = m;
    if (flush || exp_stall()) begin
      n.v = 0; n.rwe = 0; n.mwe = 0; n.ld = 0;
    end else begin
      n.v = id_valid;
      n.rwe = id_reg_wr && id_valid;
      n.mwe = id_mem_wr && id_valid;
      n.ld = id_mem_to_reg && id_valid;
      n.src = id_alu_src; n.ctr = id_alu_ctr;
      n.rs = id_rs; n.rt = id_rt; n.rw = id_rw;
      n.a = id_busA; n.b = id_busB; n.imm = id_imm;
    end
    @(posedge clk);
    m = n;
    #1;
  endtask

  task automatic id_clear();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rw = 0;
    id_busA = 0; id_busB = 0; id_imm = 0; id_alu_ctr = 0;
    id_alu_src = 0; id_reg_wr = 0; id_mem_wr = 0;
    id_mem_to_reg = 0; flush = 0;
    em_reg_wr = 0; em_rw = 0; em_result = 0;
    mw_reg_wr = 0; mw_rw = 0; mw_data = 0;
  endtask

  task automatic load_lw9();
    id_clear();
    id_valid = 1; id_rs = 1; id_rw = 9; id_alu_src = 1;
    id_reg_wr = 1; id_mem_to_reg = 1; id_imm = 32'h10;
    step();
    id_clear();
    id_valid = 1; id_rs = 2; id_rt = 9; id_rw = 3;
    id_reg_wr = 1; id_alu_ctr = 3'b001;
  endtask

  initial begin
    m = '{default: 0};
    #2;
    chk("reset_stall", stall, 0);
    chk("reset_alu_a", alu_a, 0);
    chk("reset_alu_b", alu_b, 0);
    chk("reset_valid", ex_valid, 0);
    @(negedge clk);
    rst_n = 1;
    step();

    // Bypass priority on operand A.
    id_clear();
    id_valid = 1; id_rs = 8; id_busA = 32'h11;
    step();
    id_valid = 0;
    em_reg_wr = 1; em_rw = 8; em_result = 32'h22;
    mw_reg_wr = 1; mw_rw = 8; mw_data = 32'h33;
    #1 chk("fwd_em_wins", alu_a, 32'h22);
    em_reg_wr = 0;
    #1 chk("fwd_mw", alu_a, 32'h33);
    mw_reg_wr = 0;
    #1 chk("fwd_none", alu_a, 32'h11);
    step();

    // Register zero is never bypassed.
    id_clear();
    id_valid = 1; id_rs = 0; id_busA = 0;
    step();
    em_reg_wr = 1; em_rw = 0; em_result = 32'hFFFF_FFFF;
    #1 chk("zero_no_fwd", alu_a, 32'h0);
    step();

    // Load-use stall, then the bubble.
    load_lw9();
    id_alu_src = 1;
    #1 chk("no_stall_imm", stall, 0);
    id_alu_src = 0;
    #1 chk("loaduse_stall", stall, 1);
    step();
    chk("bubble_valid", ex_valid, 0);
    chk("stall_released", stall, 0);
    step();
    chk("add_enters_ex", ex_valid, 1);

    // Flush beats the hazard.
    load_lw9();
    flush = 1;
    #1 chk("flush_no_stall", stall, 0);
    step();
    chk("flush_bubble", ex_valid, 0);
    flush = 0;

    // Store with bypassed store data.
    id_clear();
    id_valid = 1; id_alu_src = 1; id_imm = 32'h4;
    id_rt = 5; id_mem_wr = 1; id_busB = 32'h77;
    step();
    id_valid = 0;
    mw_reg_wr = 1; mw_rw = 5; mw_data = 32'hABCD;
    #1 chk("sw_alu_b", alu_b, 32'h4);
    chk("sw_store", ex_store_data, 32'hABCD);
    chk("sw_mem_wr", ex_mem_wr, 1);
    step();

    // Random traffic with a narrow register range to force overlaps.
    for (int i = 0; i < 3000; i++) begin
      id_valid      = ($urandom_range(0, 9) != 0);
      id_rs         = 5'($urandom_range(0, 3));
      id_rt         = 5'($urandom_range(0, 3));
      id_rw         = 5'($urandom_range(0, 3));
      id_busA       = $urandom;
      id_busB       = $urandom;
      id_imm        = $urandom;
      id_alu_ctr    = 3'($urandom);
      id_alu_src    = 1'($urandom);
      id_reg_wr     = 1'($urandom);
      id_mem_wr     = 1'($urandom);
      id_mem_to_reg = ($urandom_range(0, 2) == 0);
      flush         = ($urandom_range(0, 7) == 0);
      em_reg_wr     = 1'($urandom);
      em_rw         = 5'($urandom_range(0, 3));
      em_result     = $urandom;
      mw_reg_wr     = 1'($urandom);
      mw_rw         = 5'($urandom_range(0, 3));
      mw_data       = $urandom;
      step();
    end

    // Asynchronous reset in mid-cycle with a live instruction.
    id_clear();
    id_valid = 1; id_rs = 3; id_rt = 4; id_rw = 7;
    id_busA = 32'h5; id_busB = 32'h6; id_reg_wr = 1;
    id_alu_ctr = 3'b101;
    step();
    chk("pre_reset_valid", ex_valid, 1);
    id_valid = 0;
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("ar_valid", ex_valid, 0);
    chk("ar_alu_a", alu_a, 0);
    chk("ar_alu_b", alu_b, 0);
    chk("ar_store", ex_store_data, 0);
    chk("ar_ctr", alu_ctr, 0);
    chk("ar_rw", ex_rw, 0);
    chk("ar_reg_wr", ex_reg_wr, 0);
    chk("ar_stall", stall, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register plus operand forwarding and load-use hazard detection for the 5-stage pipelined CPU.
- Captures decoded instruction fields from ID each cycle.
- Drives the ALU operands and 3-bit ALU control directly, selecting between register data, EX/MEM data and MEM/WB data.
- Requests a one-cycle stall from IF/ID on a load-use hazard and inserts a bubble.

Parameters:
WIDTH, 32, datapath width
RA_W, 5, register address width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_rs  in  RA_W  rs field
id_rt  in  RA_W  rt field
id_rw  in  RA_W  destination register, already muxed by RegDst in ID
id_busA  in  WIDTH  register file read port A
id_busB  in  WIDTH  register file read port B
id_imm  in  WIDTH  extended immediate
id_alu_ctr  in  3  ALUctr encoding
id_alu_src  in  1  1: operand B = immediate
id_reg_wr  in  1  writes register file
id_mem_wr  in  1  store
id_mem_to_reg  in  1  load
flush  in  1  branch/jump taken; squash ID instruction
em_reg_wr  in  1  EX/MEM writes a register
em_rw  in  RA_W  EX/MEM destination register
em_result  in  WIDTH  EX/MEM ALU result
mw_reg_wr  in  1  MEM/WB writes a register
mw_rw  in  RA_W  MEM/WB destination register
mw_data  in  WIDTH  MEM/WB write-back data
stall  out  1  hold PC and IF/ID this cycle
ex_valid  out  1  EX holds a real instruction
alu_a  out  WIDTH  ALU operand A
alu_b  out  WIDTH  ALU operand B
alu_ctr  out  3  registered ALUctr
ex_rw  out  RA_W  registered destination register
ex_store_data  out  WIDTH  forwarded rt value for stores
ex_reg_wr, ex_mem_wr, ex_mem_to_reg  out  1 each  registered controls, gated by ex_valid

Behaviour:
- Reset, asynchronous on rst_n low:
  - All registered fields clear to 0, including ex_valid and alu_ctr.
  - Outputs after reset: alu_a=0, alu_b=0, ex_store_data=0, stall=0.
- Bubble condition: bubble = flush | stall.
- Capture on each rising edge:
  - If bubble: ex_valid, ex_reg_wr, ex_mem_wr and ex_mem_to_reg load 0; data fields are don't-care and hold their previous value.
  - Otherwise: all id_* fields load, and ex_valid <= id_valid.
  - Controls are stored ANDed with id_valid.
- Stall (combinational):
  - uses_rt = ~id_alu_src | id_mem_wr.
  - hazard = ex_valid & ex_mem_to_reg & ex_reg_wr & (ex_rw != 0) & id_valid & ((ex_rw == id_rs) | (uses_rt & ex_rw == id_rt)).
  - stall = hazard & ~flush. Flush has priority.
  - A stall lasts exactly one cycle per hazard, because the bubble clears ex_mem_to_reg.
- Forwarding (combinational on registered ex_rs/ex_rt), evaluated per operand (fwd_a from ex_rs, fwd_b from ex_rt):
  - Select EX/MEM if em_reg_wr & em_rw != 0 & em_rw == reg.
  - Else select MEM/WB if mw_reg_wr & mw_rw != 0 & mw_rw == reg.
  - Else use the registered bus value.
  - EX/MEM always wins over MEM/WB.
  - Register 0 is never forwarded.
- Operand outputs:
  - alu_a = fwd_a.
  - alu_b = ex_alu_src ? ex_imm : fwd_b.
  - ex_store_data = fwd_b, regardless of alu_src.
- Outputs are valid in the same cycle as the registered state; the block adds no latency beyond the one ID/EX register.
- Same-cycle write-back to the register being read in ID is the register file's job, via write-first bypass. This block does not handle that case.

Decomposition:
- Shared package cpu_pkg holds the ALUctr constants, which the ALU decodes bit-wise:
  - ALU_ADDU=3'b000, ALU_ADD=3'b001, ALU_OR=3'b010
  - ALU_SUBU=3'b100, ALU_SUB=3'b101, ALU_SLTU=3'b110, ALU_SLT=3'b111
- cpu_pkg also holds REG_ZERO=5'd0.
- One sub-module: forward_unit, instantiated once per operand.
  - Inputs: reg addr, reg data, em_*, mw_*.
  - Output: forwarded data.

Test Plan:
- Reset: rst_n low mid-cycle with ex_valid=1 -> all outputs 0 immediately, with no clock edge.
- Forwarding priority: EX has rs=8, busA=0x11; em_rw=8 with em_result=0x22; mw_rw=8 with mw_data=0x33 -> alu_a=0x22. Drop em_reg_wr -> alu_a=0x33. Drop both -> alu_a=0x11.
- $zero: rs=0, em_rw=0, em_reg_wr=1, em_result=0xFFFF_FFFF -> alu_a=0 (busA=0).
- Load-use: EX holds lw with ex_rw=9; ID holds add with rt=9, alu_src=0 ->
  - stall=1 for one cycle, and the next EX has ex_valid=0.
  - With ID alu_src=1, mem_wr=0 and rs≠9 -> stall=0.
- Flush during hazard: same as the load-use case plus flush=1 -> stall=0 and a bubble is inserted.
- Store: sw with alu_src=1, imm=0x4, rt=5 and mw_rw=5, mw_data=0xABCD -> alu_b=0x4, ex_store_data=0xABCD, ex_mem_wr=1.
